// File: rtl/aes128_inv_key_schedule.sv
// rtl/aes128_inv_key_schedule.sv - iterative AES-128 key schedule emitting round keys 10 down to 0
module aes128_inv_key_schedule (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  output logic         busy,
  output logic         rk_valid,
  output logic [127:0] rk,
  output logic [3:0]   rk_round,
  input  logic         rk_ack,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    EMIT   = 2'd2
  } state_t;

  // Forward AES S-box, entry 0 leftmost so SBOX[x] is S(x).
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Round constant for round index 1..10; other indices never reach the datapath.
  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Four parallel byte lookups.
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  state_t       state;
  state_t       state_next;
  logic [127:0] key_reg;
  logic [3:0]   round;
  logic         done_r;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  inv_w1, inv_w2, inv_w3;
  logic [31:0]  f0, f1, f2, f3;
  logic [31:0]  sbox_in;
  logic [31:0]  g;
  logic [3:0]   rcon_idx;
  logic [127:0] fwd_key;
  logic [127:0] inv_key;

  assign w0 = key_reg[127:96];
  assign w1 = key_reg[95:64];
  assign w2 = key_reg[63:32];
  assign w3 = key_reg[31:0];

  // One g-function shared by both directions: forward rotates the current w3,
  // inverse rotates the reconstructed previous w3.
  always_comb begin
    inv_w3 = w3 ^ w2;
    inv_w2 = w2 ^ w1;
    inv_w1 = w1 ^ w0;
    if (state == EMIT) begin
      sbox_in  = {inv_w3[23:0], inv_w3[31:24]};
      rcon_idx = round;
    end else begin
      sbox_in  = {w3[23:0], w3[31:24]};
      rcon_idx = round + 4'd1;
    end
    g       = sub_word(sbox_in) ^ {rcon_of(rcon_idx), 24'h000000};
    f0      = w0 ^ g;
    f1      = w1 ^ f0;
    f2      = w2 ^ f1;
    f3      = w3 ^ f2;
    fwd_key = {f0, f1, f2, f3};
    inv_key = {w0 ^ g, inv_w1, inv_w2, inv_w3};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: expansion ends on the step that produces round 10.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = EXPAND;
      EXPAND:  if (round == 4'd9) state_next = EMIT;
      EMIT:    if (rk_ack && (round == 4'd0)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    busy     = (state != IDLE);
    rk_valid = (state == EMIT);
  end

  // Shared key register, round counter and the one-cycle completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_reg <= '0;
      round   <= '0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            key_reg <= key;
            round   <= 4'd0;
          end
        end
        EXPAND: begin
          key_reg <= fwd_key;
          round   <= round + 4'd1;
        end
        EMIT: begin
          if (rk_ack) begin
            if (round != 4'd0) begin
              key_reg <= inv_key;
              round   <= round - 4'd1;
            end else begin
              done_r <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rk       = key_reg;
  assign rk_round = round;
  assign done     = done_r;

endmodule

// File: tb/tb_aes128_inv_key_schedule.sv
// tb/tb_aes128_inv_key_schedule.sv - self-checking bench for aes128_inv_key_schedule
module tb_aes128_inv_key_schedule;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic         busy;
  logic         rk_valid;
  logic [127:0] rk;
  logic [3:0]   rk_round;
  logic         rk_ack;
  logic         done;

  always #5 clk = ~clk;

  aes128_inv_key_schedule dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key      (key),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk       (rk),
    .rk_round (rk_round),
    .rk_ack   (rk_ack),
    .done     (done)
  );

  localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K2     = 128'h000102030405060708090a0b0c0d0e0f;

  typedef struct {
    logic [127:0] key;
    int           round;
    logic [127:0] exp;
  } vec_t;

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [7:0]   sbox_m [256];
  logic [7:0]   rcon_m [11];
  logic [127:0] got_rk [11];
  vec_t         vecs [9];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S-box from GF(2^8) inversion plus affine map, rcon by repeated doubling.
  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    rcon_m[0] = 8'h00;
    rcon_m[1] = 8'h01;
    for (int i = 2; i <= 10; i++) rcon_m[i] = xt(rcon_m[i-1]);
  endtask

  function automatic logic [127:0] model_rk(input logic [127:0] k, input int r);
    logic [31:0] w [4];
    logic [31:0] t;
    w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
    for (int i = 1; i <= r; i++) begin
      t = {w[3][23:0], w[3][31:24]};
      t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
      t = t ^ {rcon_m[i], 24'h000000};
      w[0] = w[0] ^ t;
      w[1] = w[1] ^ w[0];
      w[2] = w[2] ^ w[1];
      w[3] = w[3] ^ w[2];
    end
    return {w[0], w[1], w[2], w[3]};
  endfunction

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"},  128'(busy),     128'd0);
    check({tag, "_valid"}, 128'(rk_valid), 128'd0);
    check({tag, "_done"},  128'(done),     128'd0);
    check({tag, "_rk"},    rk,             128'd0);
    check({tag, "_round"}, 128'(rk_round), 128'd0);
  endtask

  task automatic begin_run(input logic [127:0] k);
    key   = k;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    key   = ~k;
    check("start_busy", 128'(busy), 128'd1);
  endtask

  task automatic wait_valid(input bit noise);
    int cyc = 0;
    while (!rk_valid && cyc < 40) begin
      if (noise) begin
        start  = 1'($urandom_range(1));
        rk_ack = 1'($urandom_range(1));
      end
      @(posedge clk); #1;
      cyc++;
    end
    start  = 1'b0;
    rk_ack = 1'b0;
    check("latency", 128'(cyc), 128'd10);
  endtask

  task automatic emit_run(input logic [127:0] k, input int duty, input bit noise);
    int er  = 10;
    int cyc = 0;
    bit fin = 1'b0;
    bit ack;
    while (!fin && cyc < 400) begin
      if (!rk_valid) begin
        check("emit_valid", 128'(rk_valid), 128'd1);
        break;
      end
      check("emit_round", 128'(rk_round), 128'(er));
      check("emit_key", rk, model_rk(k, er));
      check("emit_done_low", 128'(done), 128'd0);
      got_rk[er] = rk;
      ack    = (duty >= 100) || (int'($urandom_range(99)) < duty);
      rk_ack = ack;
      if (noise) start = 1'($urandom_range(1));
      @(posedge clk); #1;
      cyc++;
      if (ack) begin
        if (er == 0) fin = 1'b1;
        else er--;
      end
    end
    rk_ack = 1'b0;
    start  = 1'b0;
    if (!fin) begin
      n_cmp++;
      n_bad++;
      $display("FAIL emit_timeout: got round %0d want completion", er);
    end else begin
      if (duty >= 100) check("burst_len", 128'(cyc), 128'd11);
      check("end_done",  128'(done),     128'd1);
      check("end_busy",  128'(busy),     128'd0);
      check("end_valid", 128'(rk_valid), 128'd0);
      check("end_rk",    rk,             k);
    end
  endtask

  // Bounds the whole run should anything stall.
  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] rk_key;
    rst    = 1'b1;
    start  = 1'b0;
    rk_ack = 1'b0;
    key    = '0;
    build_tables();

    vecs[0] = '{K1, 10, K1_R10};
    vecs[1] = '{K1,  1, 128'ha0fafe1788542cb123a339392a6c7605};
    vecs[2] = '{K1,  0, K1};
    vecs[3] = '{K1,  2, 128'hf2c295f27a96b9435935807a7359f67f};
    vecs[4] = '{K1,  5, 128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    vecs[5] = '{K1,  9, 128'hac7766f319fadc2128d12941575c006e};
    vecs[6] = '{K2, 10, 128'h13111d7fe3944a17f307a78b4d2b30c5};
    vecs[7] = '{K2,  1, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe};
    vecs[8] = '{K2,  0, K2};

    repeat (2) @(posedge clk);
    #1;
    check_idle_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Hold with no acks: round 10 stays put.
    begin_run(K1);
    wait_valid(1'b0);
    for (int i = 0; i < 20; i++) begin
      check("hold_rk", rk, K1_R10);
      check("hold_round", 128'(rk_round), 128'd10);
      @(posedge clk); #1;
    end
    emit_run(K1, 100, 1'b0);
    @(posedge clk); #1;
    check("done_one_cycle", 128'(done), 128'd0);

    // Directed round-key table against full burst runs.
    for (int v = 0; v < 9; v++) begin
      begin_run(vecs[v].key);
      wait_valid(1'b0);
      emit_run(vecs[v].key, 100, 1'b0);
      @(posedge clk); #1;
      check($sformatf("vec%0d_round%0d", v, vecs[v].round), got_rk[vecs[v].round], vecs[v].exp);
    end

    // Stray start/ack during expansion and stray start during emission.
    begin_run(K1);
    wait_valid(1'b1);
    emit_run(K1, 50, 1'b1);
    // Start in the done cycle begins a new run at once.
    key   = K2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("restart_busy", 128'(busy), 128'd1);
    wait_valid(1'b0);
    emit_run(K2, 100, 1'b0);
    @(posedge clk); #1;

    // Reset during expansion at round 5.
    begin_run(K1);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_idle_zero("rst_expand");
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_expand_nodone", 128'(done), 128'd0);
    @(posedge clk); #1;
    begin_run(K2);
    wait_valid(1'b0);
    emit_run(K2, 100, 1'b0);
    @(posedge clk); #1;

    // Reset during emission at round 3.
    begin_run(K1);
    wait_valid(1'b0);
    rk_ack = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    rk_ack = 1'b0;
    check("pre_rst_round", 128'(rk_round), 128'd3);
    rst = 1'b1;
    #1;
    check_idle_zero("rst_emit");
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_emit_nodone", 128'(done), 128'd0);
    @(posedge clk); #1;
    begin_run(K1);
    wait_valid(1'b0);
    emit_run(K1, 100, 1'b0);
    @(posedge clk); #1;

    // Random keys with random acks.
    for (int n = 0; n < 200; n++) begin
      rk_key = {$urandom, $urandom, $urandom, $urandom};
      begin_run(rk_key);
      wait_valid(1'b0);
      emit_run(rk_key, 50, 1'b0);
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
